// File: rtl/text_mode_renderer.sv
// rtl/text_mode_renderer.sv - three-stage text-mode pixel pipeline: cell lookup, glyph fetch, colour select
// S0 addresses VRAM, S1 addresses the font ROM, S2 picks the colour; pixel_color appears 3 cycles after its coordinate.
module text_mode_renderer #(
  parameter int CHAR_WIDTH   = 8,
  parameter int CHAR_HEIGHT  = 16,
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int COORD_W      = 10,
  parameter int VRAM_AW      = 12,
  parameter int ROM_AW       = 12,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [COORD_W-1:0]    pixel_x,
  input  logic [COORD_W-1:0]    pixel_y,
  input  logic                  pixel_valid,
  input  logic                  frame_start,
  input  logic [4:0]            row_offset,
  input  logic                  cursor_enable,
  input  logic [VRAM_AW-1:0]    cursor_addr,
  input  logic [7:0]            border_color,
  output logic                  vram_rd_en,
  output logic [VRAM_AW-1:0]    vram_addr,
  input  logic [7:0]            vram_char,
  input  logic [15:0]           vram_attr,
  output logic                  rom_rd_en,
  output logic [ROM_AW-1:0]     rom_addr,
  input  logic [CHAR_WIDTH-1:0] rom_data,
  output logic [7:0]            pixel_color,
  output logic                  pixel_out_valid
);
  localparam int CW_LOG = $clog2(CHAR_WIDTH);
  localparam int CH_LOG = $clog2(CHAR_HEIGHT);
  localparam int XW = (CW_LOG > 0) ? CW_LOG : 1;
  localparam int LW = (CH_LOG > 0) ? CH_LOG : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [31:0] ACT_W = 32'(COLS * CHAR_WIDTH);
  localparam logic [31:0] ACT_H = 32'(ROWS * CHAR_HEIGHT);

  logic [4:0]         off_q, off_d;
  logic               cursor_en_q;
  logic [VRAM_AW-1:0] cursor_addr_q;
  logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;

  logic               v1_q, act1_q, cur1_q;
  logic [XW-1:0]      xoff1_q;
  logic [LW-1:0]      line1_q;
  logic [7:0]         bord1_q;
  logic               v2_q, act2_q, cur2_q;
  logic [XW-1:0]      xoff2_q;
  logic [7:0]         bord2_q, fg2_q, bg2_q;
  logic               valid_q;
  logic [7:0]         color_q, color_d;

  logic [31:0]        col_w, srow_w, line_w, vrow_w, vcell_w, scell_w;
  logic               act1_d, cur1_d;
  logic [XW-1:0]      xoff1_d;
  logic [LW-1:0]      line1_d;
  logic [CHAR_WIDTH-1:0] glyph_sh;

  // Cursor qualification is folded in at S0 so a pixel sees the sampled state of its own cycle.
  always_comb begin
    col_w   = 32'(pixel_x) >> CW_LOG;
    srow_w  = 32'(pixel_y) >> CH_LOG;
    line_w  = 32'(pixel_y) & 32'(CHAR_HEIGHT - 1);
    vrow_w  = srow_w + 32'(off_q);
    if (vrow_w >= 32'(ROWS)) vrow_w = vrow_w - 32'(ROWS);
    vcell_w = vrow_w * 32'(COLS) + col_w;
    scell_w = srow_w * 32'(COLS) + col_w;
    act1_d  = (32'(pixel_x) < ACT_W) && (32'(pixel_y) < ACT_H);
    xoff1_d = XW'(32'(pixel_x) & 32'(CHAR_WIDTH - 1));
    line1_d = LW'(line_w);
    cur1_d  = cursor_en_q & blink_q & (scell_w == 32'(cursor_addr_q)) &
              ((CHAR_HEIGHT < 2) || (line_w >= 32'(CHAR_HEIGHT - 2)));
  end

  assign vram_rd_en = pixel_valid & act1_d;
  assign vram_addr  = vram_rd_en ? VRAM_AW'(vcell_w) : '0;
  assign rom_rd_en  = v1_q & act1_q;
  assign rom_addr   = rom_rd_en ? ROM_AW'(32'(vram_char) * 32'(CHAR_HEIGHT) + 32'(line1_q)) : '0;

  always_comb begin
    glyph_sh = rom_data << xoff2_q;
    if (!act2_q)                          color_d = bord2_q;
    else if (cur2_q | glyph_sh[CHAR_WIDTH-1]) color_d = fg2_q;
    else                                  color_d = bg2_q;
  end

  always_comb begin
    off_d       = off_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (frame_start) begin
      off_d = (32'(row_offset) < 32'(ROWS)) ? row_offset : 5'd0;
      if (32'(blink_cnt_q) == 32'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = BW'(blink_cnt_q + 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q <= '0; cursor_en_q <= 1'b0; cursor_addr_q <= '0;
      blink_cnt_q <= '0; blink_q <= 1'b1;
      v1_q <= 1'b0; act1_q <= 1'b0; cur1_q <= 1'b0; xoff1_q <= '0; line1_q <= '0; bord1_q <= '0;
      v2_q <= 1'b0; act2_q <= 1'b0; cur2_q <= 1'b0; xoff2_q <= '0; bord2_q <= '0;
      fg2_q <= '0; bg2_q <= '0;
      valid_q <= 1'b0; color_q <= '0;
    end else begin
      off_q       <= off_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      if (frame_start) begin
        cursor_en_q   <= cursor_enable;
        cursor_addr_q <= cursor_addr;
      end
      v1_q    <= pixel_valid;
      act1_q  <= act1_d;
      cur1_q  <= cur1_d;
      xoff1_q <= xoff1_d;
      line1_q <= line1_d;
      bord1_q <= border_color;
      v2_q    <= v1_q;
      act2_q  <= act1_q;
      cur2_q  <= cur1_q;
      xoff2_q <= xoff1_q;
      bord2_q <= bord1_q;
      fg2_q   <= vram_attr[15:8];
      bg2_q   <= vram_attr[7:0];
      valid_q <= v2_q;
      if (v2_q) color_q <= color_d;
    end
  end

  assign pixel_color     = color_q;
  assign pixel_out_valid = valid_q;
endmodule

// File: tb/tb_text_mode_renderer.sv
// tb/tb_text_mode_renderer.sv - scoreboard bench for text_mode_renderer with memory models and a reference model
module tb_text_mode_renderer;
  localparam int CW = 8, CH = 16, COLS = 80, ROWS = 30, BF = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  pixel_x = '0, pixel_y = '0;
  logic        pixel_valid = 1'b0, frame_start = 1'b0, cursor_enable = 1'b0;
  logic [4:0]  row_offset = '0;
  logic [11:0] cursor_addr = '0;
  logic [7:0]  border_color = '0;
  logic        vram_rd_en, rom_rd_en, pixel_out_valid;
  logic [11:0] vram_addr, rom_addr;
  logic [7:0]  vram_char = '0;
  logic [15:0] vram_attr = '0;
  logic [7:0]  rom_data = '0;
  logic [7:0]  pixel_color;

  text_mode_renderer #(.BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .frame_start(frame_start), .row_offset(row_offset), .cursor_enable(cursor_enable),
    .cursor_addr(cursor_addr), .border_color(border_color), .vram_rd_en(vram_rd_en),
    .vram_addr(vram_addr), .vram_char(vram_char), .vram_attr(vram_attr), .rom_rd_en(rom_rd_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .pixel_color(pixel_color), .pixel_out_valid(pixel_out_valid)
  );

  always #5 clk = ~clk;

  logic [7:0]  vmem [0:4095];
  logic [15:0] amem [0:4095];
  logic [7:0]  fmem [0:4095];

  always @(posedge clk) begin
    if (vram_rd_en) begin
      vram_char <= vmem[vram_addr];
      vram_attr <= amem[vram_addr];
    end
    if (rom_rd_en) rom_data <= fmem[rom_addr];
  end

  typedef struct { logic [7:0] color; int due; } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int errors = 0, checks = 0, cyc = 0;
  int off_m = 0, cen_m = 0, caddr_m = 0, nfs = 0;
  int prev_en = 0, prev_vaddr = 0, prev_line = 0;
  logic [7:0] last_color = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit pv, input int x, input int y, input bit fs, input int ro,
                      input bit ce, input int ca, input int bc, input bit rst);
    int col, srow, line, xoff, vrow, vaddr, ch, g, fg, bg, color, en, phase, cur;
    @(posedge clk); #1;
    rst_n = !rst; pixel_valid = pv; pixel_x = 10'(x); pixel_y = 10'(y);
    frame_start = fs; row_offset = 5'(ro); cursor_enable = ce; cursor_addr = 12'(ca);
    border_color = 8'(bc);
    @(negedge clk);
    if (rst) begin
      chk("rst_out_valid", int'(pixel_out_valid), 0);
      chk("rst_color", int'(pixel_color), 0);
      chk("rst_rom_en", int'(rom_rd_en), 0);
      chk("rst_vram_en", int'(vram_rd_en), 0);
      q.delete();
      off_m = 0; cen_m = 0; caddr_m = 0; nfs = 0; prev_en = 0;
      return;
    end
    col = x / CW; srow = y / CH; line = y % CH; xoff = x % CW;
    vrow = (srow + off_m) % ROWS;
    vaddr = vrow * COLS + col;
    en = (pv && x < COLS * CW && y < ROWS * CH) ? 1 : 0;
    chk("vram_rd_en", int'(vram_rd_en), en);
    chk("vram_addr", int'(vram_addr), en ? vaddr : 0);
    chk("rom_rd_en", int'(rom_rd_en), prev_en);
    chk("rom_addr", int'(rom_addr), prev_en ? int'(vmem[prev_vaddr]) * CH + prev_line : 0);
    if (pv) begin
      if (x >= COLS * CW || y >= ROWS * CH) begin
        color = bc;
      end else begin
        ch = vmem[vaddr]; fg = amem[vaddr][15:8]; bg = amem[vaddr][7:0];
        g = fmem[ch * CH + line];
        phase = ((nfs / BF) % 2 == 0) ? 1 : 0;
        cur = (cen_m != 0 && srow * COLS + col == caddr_m && phase == 1 && line >= CH - 2) ? 1 : 0;
        color = (cur == 1 || ((g >> (CW - 1 - xoff)) & 1) == 1) ? fg : bg;
      end
      mon_e.color = 8'(color); mon_e.due = cyc + 3;
      q.push_back(mon_e);
    end
    if (fs) begin
      off_m = (ro < ROWS) ? ro : 0; cen_m = ce; caddr_m = ca; nfs++;
    end
    prev_en = en; prev_vaddr = vaddr; prev_line = line;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pix(input int x, input int y, input int bc);
    step(1, x, y, 0, 0, 0, 0, bc, 0);
  endtask

  exp_t out_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      last_color = '0;
    end else if (pixel_out_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got color %0h with nothing in flight (cycle %0d)", pixel_color, cyc);
      end else begin
        out_e = q.pop_front();
        chk("out_cycle", cyc, out_e.due);
        chk("pixel_color", int'(pixel_color), int'(out_e.color));
      end
      last_color = pixel_color;
    end else begin
      chk("hold_color", int'(pixel_color), int'(last_color));
      if (q.size() > 0 && q[0].due <= cyc) begin
        checks++; errors++;
        $display("FAIL missing_output: got no valid expected color %0h (cycle %0d)", q[0].color, cyc);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    int x, y, ca;
    for (int i = 0; i < 4096; i++) begin
      vmem[i] = 8'($urandom); amem[i] = 16'($urandom); fmem[i] = 8'($urandom);
    end
    vmem[0] = 8'h41; amem[0] = 16'h0F00; fmem[12'h410] = 8'h80;
    vmem[80] = 8'h41; amem[80] = 16'h2A05; fmem[12'h411] = 8'h01;
    vmem[81] = 8'h20; amem[81] = 16'h3C07;
    fmem[12'h20D] = 8'h00; fmem[12'h20E] = 8'h00;

    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);

    pix(0, 0, 0); idle(3);
    pix(7, 17, 0); pix(6, 17, 0); idle(3);
    pix(640, 0, 8'h1C); pix(0, 480, 8'h1C); idle(3);

    step(0, 0, 0, 1, 29, 0, 0, 0, 0); pix(0, 32, 0); idle(3);
    step(0, 0, 0, 1, 31, 0, 0, 0, 0); pix(0, 32, 0); idle(3);

    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1, 81, 0, 0);
    pix(8, 30, 0); pix(8, 29, 0); idle(3);
    step(0, 0, 0, 1, 0, 1, 81, 0, 0); step(0, 0, 0, 1, 0, 1, 81, 0, 0);
    pix(8, 30, 0); idle(3);
    step(0, 0, 0, 1, 0, 1, 81, 0, 0); step(0, 0, 0, 1, 0, 1, 81, 0, 0);
    pix(8, 30, 0); pix(8, 29, 0);
    step(1, 8, 30, 1, 0, 0, 81, 0, 0); pix(8, 30, 0); idle(3);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        if ($urandom_range(0, 1) == 1) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          x = $urandom_range(0, 63); y = $urandom_range(0, 63);
        end else begin
          x = $urandom_range(0, 700); y = $urandom_range(0, 520);
        end
        ca = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2399)
                                         : $urandom_range(0, 3) * COLS + $urandom_range(0, 7);
        step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, x, y,
             ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0, $urandom_range(0, 31),
             ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, ca, $urandom_range(0, 255), 0);
      end
    end
    idle(6);
    chk("drain_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
